// File: rtl/fadd_arbiter.sv
// fadd_arbiter: shares one combinational single-precision adder (fadd)
// between NREQ requesters with round-robin arbitration. Operands are
// registered on grant, the adder result is registered one cycle later and
// presented on a single response channel tagged with the requester index.
//
// Ports:
//   clk        sole clock, rising edge
//   rstn       asynchronous active-low reset
//   req_valid  [NREQ]      requester i presents an operation
//   req_ready  [NREQ]      requester i granted this cycle (one-hot or zero)
//   req_x1     [32*NREQ]   operand 1, requester i at [32i+31:32i]
//   req_x2     [32*NREQ]   operand 2, same packing
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_id     [IDW]       owning requester index
//   rsp_y      [32]        sum
//   rsp_ovf    overflow flag (finite operands, infinite result)
//   ovf_cnt    [16]        only with FADD_ARB_OVFCNT_EN: saturating count of
//                          accepted responses that carried rsp_ovf
//
// Optional feature macro: FADD_ARB_OVFCNT_EN

// fadd: combinational IEEE-754 single-precision add, round-to-nearest-even.
// Subnormals are handled. Any NaN input, or Inf + -Inf, yields the canonical
// quiet NaN 0xFFC00000. An Inf input passes through with ovf=0; ovf is set
// only when finite operands round to infinity. Exact cancellation gives +0,
// while -0 + -0 gives -0.
module fadd (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    logic [31:0] a, b;
    logic [7:0]  ea, eb, d;
    logic [26:0] ma, mb, mb_sh, norm;
    logic [27:0] sum;
    logic [9:0]  e, lz10, sh;
    logic [24:0] rnd;
    logic        sub, inc;
    logic        nan1, nan2, inf1, inf2;

    // Subnormals use exponent 1 with no hidden bit.
    function automatic logic [7:0] eff_exp(input logic [7:0] ex);
        return (ex == 8'd0) ? 8'd1 : ex;
    endfunction

    // Right shift that folds every shifted-out bit into bit 0 (sticky).
    function automatic logic [26:0] shr_sticky(input logic [26:0] v, input logic [7:0] s);
        logic [26:0] shifted;
        logic [26:0] mask;
        if (s >= 8'd27) begin
            return {26'd0, |v};
        end
        shifted = v >> s;
        mask    = ~({27{1'b1}} << s);
        return {shifted[26:1], shifted[0] | (|(v & mask))};
    endfunction

    function automatic logic [4:0] lzc(input logic [26:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd27;
        hit = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (v[i] && !hit) begin
                n   = 5'(26 - i);
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        // Order operands by magnitude so the result sign is that of a.
        if (x1[30:0] >= x2[30:0]) begin
            a = x1;
            b = x2;
        end else begin
            a = x2;
            b = x1;
        end
        ea    = a[30:23];
        eb    = b[30:23];
        ma    = {(ea != 8'd0), a[22:0], 3'b000};
        mb    = {(eb != 8'd0), b[22:0], 3'b000};
        d     = eff_exp(ea) - eff_exp(eb);
        mb_sh = shr_sticky(mb, d);
        sub   = a[31] ^ b[31];
        sum   = sub ? ({1'b0, ma} - {1'b0, mb_sh}) : ({1'b0, ma} + {1'b0, mb_sh});
        e     = {2'b00, eff_exp(ea)};
        lz10  = {5'd0, lzc(sum[26:0])};
        sh    = '0;
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 10'd1;
        end else begin
            // Stop normalising at exponent 1; what remains is subnormal.
            sh   = (lz10 < e - 10'd1) ? lz10 : (e - 10'd1);
            norm = sum[26:0] << sh;
            e    = e - sh;
        end
        inc = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[26:3]} + {24'd0, inc};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'd1;
        end

        nan1 = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
        nan2 = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
        inf1 = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
        inf2 = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);

        if (nan1 || nan2 || (inf1 && inf2 && (x1[31] ^ x2[31]))) begin
            y = 32'hFFC0_0000;
        end else if (inf1) begin
            y = x1;
        end else if (inf2) begin
            y = x2;
        end else if (sum == 28'd0) begin
            y = {~sub & a[31], 31'd0};
        end else if (e >= 10'd255) begin
            y   = {a[31], 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            y = {a[31], (rnd[23] ? e[7:0] : 8'h00), rnd[22:0]};
        end
    end
endmodule

module fadd_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [32*NREQ-1:0] req_x1,
    input  logic [32*NREQ-1:0] req_x2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_y,
    output logic              rsp_ovf
`ifdef FADD_ARB_OVFCNT_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [NREQ-1:0] gnt_vec;
    logic [IDW-1:0]  gnt_id;
    logic            found, can_grant, grant;
    logic [31:0]     sel_x1, sel_x2;
    logic [31:0]     x1_p0, x2_p0;
    logic [IDW-1:0]  id_p0;
    logic [31:0]     fadd_y;
    logic            fadd_ovf;

    // Round-robin pick: first valid index at or after ptr, wrapping at NREQ.
    always_comb begin
        gnt_vec = '0;
        gnt_id  = '0;
        found   = 1'b0;
        sel_x1  = '0;
        sel_x2  = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    found      = 1'b1;
                    gnt_vec[i] = 1'b1;
                    gnt_id     = IDW'(i);
                    sel_x1     = req_x1[32*i +: 32];
                    sel_x2     = req_x2[32*i +: 32];
                end
            end
        end
    end

    // A new operation may start when idle, or when the held result leaves
    // on this same edge.
    assign can_grant = rstn && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign req_ready = can_grant ? gnt_vec : '0;
    assign grant     = |req_ready;
    assign ptr_nxt   = (gnt_id == IDW'(NREQ - 1)) ? '0 : (gnt_id + IDW'(1));
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = grant ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    fadd u_fadd (
        .x1  (x1_p0),
        .x2  (x2_p0),
        .y   (fadd_y),
        .ovf (fadd_ovf)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            x1_p0   <= '0;
            x2_p0   <= '0;
            id_p0   <= '0;
            rsp_id  <= '0;
            rsp_y   <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            // Stage 0: operands of the granted requester
            if (grant) begin
                x1_p0 <= sel_x1;
                x2_p0 <= sel_x2;
                id_p0 <= gnt_id;
                ptr   <= ptr_nxt;
            end
            // Stage 1: adder result, held while in RESP
            if (state == EXEC) begin
                rsp_y   <= fadd_y;
                rsp_ovf <= fadd_ovf;
                rsp_id  <= id_p0;
            end
        end
    end

`ifdef FADD_ARB_OVFCNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt <= '0;
        end else if (rsp_valid && rsp_ready && rsp_ovf && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif
endmodule
